// File: rtl/int_req_ctrl.sv
// int_req_ctrl: edge-detected, masked, fixed-priority nested interrupt requester with per-level EPC stack
module int_req_ctrl #(
    parameter int PCW = 32
) (
    input  logic           in_CLK,
    input  logic           in_RST,
    input  logic [2:0]     in_IRQ,
    input  logic [2:0]     in_MASK,
    input  logic           in_IE,
    input  logic [PCW-1:0] in_PC,
    input  logic           in_eret,
    output logic           out_BK,
    output logic [1:0]     out_code,
    output logic [PCW-1:0] out_EPC,
    output logic [2:0]     out_pending,
    output logic [2:0]     out_svc
);
    typedef enum logic [1:0] {IDLE, BRK, SETTLE} state_t;

    state_t         state, state_n;
    logic [2:0]     irq_prev, pending, svc, rise, pend_n, svc_n, set_oh, clr_oh;
    logic [1:0]     cand, cur, code_n;
    logic           take, ret;
    logic [PCW-1:0] epc_n;
    logic [PCW-1:0] stack [3];
    logic [PCW-1:0] stack_n [3];

    function automatic logic [1:0] top(input logic [2:0] v);
        return v[2] ? 2'd3 : v[1] ? 2'd2 : v[0] ? 2'd1 : 2'd0;
    endfunction

    // Arbitration, FSM next state and next values of every register
    always_comb begin
        rise    = in_IRQ & ~irq_prev;
        cand    = top(pending & in_MASK);
        cur     = top(svc);
        ret     = in_eret && cur != 2'd0;
        take    = state == IDLE && in_IE && cand > cur && !in_eret;
        state_n = state == BRK ? SETTLE : take ? BRK : IDLE;
        set_oh  = take ? 3'b001 << (cand - 2'd1) : 3'b000;
        clr_oh  = ret ? 3'b001 << (cur - 2'd1) : 3'b000;
        pend_n  = (pending | rise) & ~set_oh;
        svc_n   = (svc | set_oh) & ~clr_oh;
        code_n  = top(svc_n);
        for (int i = 0; i < 3; i++) stack_n[i] = set_oh[i] ? in_PC : stack[i];
        epc_n   = code_n == 2'd0 ? '0 : stack_n[code_n - 2'd1];
    end

    // State register and registered outputs; reset wins over everything
    always_ff @(posedge in_CLK) begin
        if (!in_RST) begin
            state    <= IDLE;
            irq_prev <= 3'b111;
            pending  <= '0;
            svc      <= '0;
            out_BK   <= 1'b0;
            out_code <= '0;
            out_EPC  <= '0;
            for (int i = 0; i < 3; i++) stack[i] <= '0;
        end else begin
            state    <= state_n;
            irq_prev <= in_IRQ;
            pending  <= pend_n;
            svc      <= svc_n;
            out_BK   <= take;
            out_code <= code_n;
            out_EPC  <= epc_n;
            for (int i = 0; i < 3; i++) stack[i] <= stack_n[i];
        end
    end

    assign out_pending = pending;
    assign out_svc     = svc;
endmodule

// File: tb/tb_int_req_ctrl.sv
// tb_int_req_ctrl: directed stimulus with a scoreboard of expected break events
module tb_int_req_ctrl;
    logic        clk = 1'b0, rst = 1'b0, ie = 1'b1, eret = 1'b0;
    logic [2:0]  irq = 3'b010, mask = 3'b111;
    logic [31:0] pc = '0;
    logic        bk;
    logic [1:0]  code;
    logic [31:0] epc;
    logic [2:0]  pend, svc;

    typedef struct {
        logic [1:0]  code;
        logic [31:0] epc;
        logic [2:0]  svc;
        logic [2:0]  pend;
    } exp_t;
    exp_t q[$];
    int checks = 0, errors = 0;

    int_req_ctrl #(.PCW(32)) dut (
        .in_CLK(clk), .in_RST(rst), .in_IRQ(irq), .in_MASK(mask), .in_IE(ie),
        .in_PC(pc), .in_eret(eret), .out_BK(bk), .out_code(code), .out_EPC(epc),
        .out_pending(pend), .out_svc(svc)
    );

    always #5 clk = ~clk;

    // Monitor: every break pulse must match the oldest expected break
    always @(negedge clk) begin
        if (bk) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL bk_unexpected code=%0d epc=%0h svc=%b pend=%b", code, epc, svc, pend);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (code !== e.code || epc !== e.epc || svc !== e.svc || pend !== e.pend) begin
                    errors++;
                    $display("FAIL bk_event got code=%0d epc=%0h svc=%b pend=%b want code=%0d epc=%0h svc=%b pend=%b",
                             code, epc, svc, pend, e.code, e.epc, e.svc, e.pend);
                end
            end
        end
    end

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic expect_bk(logic [1:0] c, logic [31:0] e, logic [2:0] s, logic [2:0] p);
        q.push_back('{code: c, epc: e, svc: s, pend: p});
    endtask

    initial begin
        // reset with a line held high
        tick(3);
        chk("rst_bk", 32'(bk), 0);
        chk("rst_code", 32'(code), 0);
        chk("rst_epc", epc, 0);
        chk("rst_pend", 32'(pend), 0);
        chk("rst_svc", 32'(svc), 0);
        rst = 1'b1;
        tick(10);
        chk("held_pend", 32'(pend), 0);
        irq = 3'b000;
        tick();
        // single level-1 break
        irq = 3'b001; pc = 32'h100;
        expect_bk(2'd1, 32'h100, 3'b001, 3'b000);
        tick();
        chk("l1_pend_set", 32'(pend), 32'b001);
        chk("l1_bk_wait", 32'(bk), 0);
        tick();
        chk("l1_bk_high", 32'(bk), 1);
        tick();
        chk("l1_bk_low", 32'(bk), 0);
        irq = 3'b000;
        tick();
        // preemption by level 3 then unwinding
        irq = 3'b100; pc = 32'h204;
        expect_bk(2'd3, 32'h204, 3'b101, 3'b000);
        tick(4);
        irq = 3'b000;
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("eret1_code", 32'(code), 1);
        chk("eret1_epc", epc, 32'h100);
        chk("eret1_svc", 32'(svc), 32'b001);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("eret2_code", 32'(code), 0);
        chk("eret2_svc", 32'(svc), 0);
        chk("eret2_epc", epc, 0);
        // simultaneous rises, lower one waits for eret
        irq = 3'b011; pc = 32'h300;
        expect_bk(2'd2, 32'h300, 3'b010, 3'b001);
        tick(4);
        chk("sim_pend", 32'(pend), 32'b001);
        chk("sim_code", 32'(code), 2);
        irq = 3'b000; pc = 32'h400; eret = 1'b1;
        expect_bk(2'd1, 32'h400, 3'b001, 3'b000);
        tick();
        eret = 1'b0;
        chk("eret_blocks_bk", 32'(bk), 0);
        chk("eret_code0", 32'(code), 0);
        tick();
        chk("after_eret_bk", 32'(bk), 1);
        tick(2);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("sim_clear", 32'(svc), 0);
        // masked request stays pending
        mask = 3'b011; irq = 3'b100; pc = 32'h500;
        tick(3);
        chk("mask_pend", 32'(pend), 32'b100);
        chk("mask_svc", 32'(svc), 0);
        irq = 3'b000; mask = 3'b111;
        expect_bk(2'd3, 32'h500, 3'b100, 3'b000);
        tick(4);
        chk("unmask_code", 32'(code), 3);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        // reset in the middle of a break
        irq = 3'b001; pc = 32'h600;
        expect_bk(2'd1, 32'h600, 3'b001, 3'b000);
        tick(2);
        chk("brk_bk", 32'(bk), 1);
        rst = 1'b0;
        tick();
        chk("midrst_bk", 32'(bk), 0);
        chk("midrst_code", 32'(code), 0);
        chk("midrst_epc", epc, 0);
        chk("midrst_svc", 32'(svc), 0);
        chk("midrst_pend", 32'(pend), 0);
        rst = 1'b1; irq = 3'b000;
        tick();
        irq = 3'b010; pc = 32'h700;
        expect_bk(2'd2, 32'h700, 3'b010, 3'b000);
        tick(4);
        chk("post_rst_epc", epc, 32'h700);
        tick(3);
        chk("queue_empty", 32'(q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
